ifu_pc_gen: RTL and testbench
=============================

Name: ifu_pc_gen

Overview:
- Parametrised next-generation PC generator for the IFU front end.
- Replaces the single-jump, fixed-+4 PC register with:
  - N prioritised redirect channels (e.g. trap, branch resolve, predictor);
  - valid/ready fetch-request handshake;
  - configurable fetch-block width;
  - redirect epoch tag, so the fetch/decode stages can discard stale requests.
- Sits between the redirect sources (EXU/CSR/BPU) and the instruction-memory request port.

Parameters:
- ADDR_W, 32: PC/address width.
- RESET_ADDR, 32'h0000_0000: PC after reset.
- FETCH_BYTES, 4: bytes per fetch request; power of two, 4 or 8.
- N_REDIR, 3: number of redirect channels; index 0 has highest priority.
- EPOCH_W, 3: width of the redirect epoch counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- redir_valid_i  input  N_REDIR  per-channel redirect request.
- redir_addr_i  input  N_REDIR*ADDR_W  packed targets; channel k occupies bits [k*ADDR_W +: ADDR_W].
- hold_i  input  1  pipeline stall; freezes PC issue.
- fetch_ready_i  input  1  memory port accepts the request.
- fetch_valid_o  output  1  fetch request valid.
- pc_o  output  ADDR_W  fetch address.
- epoch_o  output  EPOCH_W  epoch tag of the current request.
- redir_taken_o  output  N_REDIR  one-hot; marks the channel accepted this cycle.
- misalign_o  output  1  only with IFU_PC_ALIGN_CHK_EN; tied 0 otherwise.

Behaviour:
- States: BOOT, RUN, FAULT.
  - BOOT is entered only on reset and lasts exactly one cycle, then goes to RUN.
  - FAULT exists only with the optional feature enabled.
- Reset values: pc_o=RESET_ADDR, epoch_o=0, state=BOOT, fetch_valid_o=0, redir_taken_o=0, misalign_o=0.
- Redirect arbitration:
  - any_redir = |redir_valid_i.
  - The winner is the lowest-index valid channel.
  - redir_taken_o is the winner's one-hot, combinational, in the same cycle.
- Redirect handling:
  - Always accepted, in any state, regardless of hold_i or fetch_ready_i.
  - Next cycle: pc_o = winner target; epoch_o = epoch_o+1, wrapping modulo 2^EPOCH_W; state = RUN.
- fetch_valid_o = (state==RUN) & ~hold_i & ~any_redir. This is combinational; redirect and hold suppress issue in the same cycle.
- Sequential advance:
  - Occurs on handshake (fetch_valid_o & fetch_ready_i).
  - pc_o <= (pc_o & ~(FETCH_BYTES-1)) + FETCH_BYTES, i.e. the next aligned block.
  - A mid-block redirect target therefore fetches its partial block once, then realigns.
- Wrap-around: the addition is modulo 2^ADDR_W; all-ones block + FETCH_BYTES → 0, with no flag.
- While fetch_valid_o=1 and fetch_ready_i=0, pc_o and epoch_o stay stable.
- hold_i=1 with no redirect: pc_o and epoch_o are held; fetch_valid_o=0.
- Priority per cycle: rst > redirect > hold > handshake advance > hold value.
- Reset mid-operation: all state returns to reset values on the next edge; pending inputs are ignored that cycle.
- Targets with addr[1:0]!=0, feature disabled: bits [1:0] are cleared on load.

Optional Feature:
- Macro: IFU_PC_ALIGN_CHK_EN.
- Enabled, on a winner target with addr[1:0]!=0:
  - pc_o is loaded with the raw address and epoch increments;
  - state goes to FAULT, and misalign_o=1 while in FAULT;
  - fetch_valid_o=0 while in FAULT;
  - only a later redirect or rst leaves FAULT.
- Disabled: no FAULT state; low bits are cleared as above; misalign_o is tied 0.

Decomposition:
- Shared package/defines contents:
  - state encodings (BOOT/RUN/FAULT);
  - default RESET_ADDR;
  - alignment-mask helper constant derived from FETCH_BYTES.
- One sub-module, ifu_redir_arb: parametrised N_REDIR fixed-priority encoder plus target mux. Outputs are one-hot grant, any-valid and selected address; purely combinational.

Test Plan:
- Reset, then release with fetch_ready_i=1, RESET_ADDR=0:
  - cycle 1: valid=0 (BOOT);
  - following cycles: pc_o 0x0, 0x4, 0x8, …; epoch_o=0.
- fetch_ready_i=0 for 3 cycles at pc 0x8 → pc_o stays 0x8 and fetch_valid_o stays 1; on ready → 0xC.
- redir_valid_i=3'b110, targets ch1=0x100, ch2=0x200:
  - redir_taken_o=3'b010 and fetch_valid_o=0 that cycle;
  - next cycle pc_o=0x100, epoch_o=1.
- hold_i=1 together with redirect on ch0 to 0x40 → next cycle pc_o=0x40, epoch incremented; while hold stays 1, valid=0 and pc held.
- FETCH_BYTES=8, redirect to 0x1C → issued PCs 0x1C, 0x20, 0x28. pc 0xFFFF_FFF8 → next 0x0000_0000.
- IFU_PC_ALIGN_CHK_EN on:
  - redirect to 0x102 → FAULT, misalign_o=1, valid=0;
  - redirect to 0x200 → RUN at 0x200, misalign_o=0. Eight redirects → epoch wraps 7→0.

Source files
------------

// File: rtl/ifu_pc_gen_pkg.sv
// ifu_pc_gen_pkg: shared types and constants for the IFU PC generator.
//   pc_state_e          - BOOT / RUN / FAULT state encoding
//   DEFAULT_RESET_ADDR  - default PC after reset
//   INSTR_ALIGN_BITS    - low address bits that must be zero for an aligned instruction
//   blk_off_mask()      - byte-offset mask of a fetch block (FETCH_BYTES-1)
package ifu_pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;
    localparam int unsigned INSTR_ALIGN_BITS   = 2;

    // Offset-within-block mask; the block base is pc & ~blk_off_mask(FETCH_BYTES).
    function automatic int unsigned blk_off_mask(input int unsigned fetch_bytes);
        return fetch_bytes - 1;
    endfunction

endpackage

// File: rtl/ifu_redir_arb.sv
// ifu_redir_arb: fixed-priority redirect arbiter, channel 0 highest priority.
//   valid      in   per-channel request
//   addr       in   packed targets, channel k at [k*ADDR_W +: ADDR_W]
//   grant      out  one-hot winner (zero when no request)
//   any_valid  out  OR of all requests
//   target     out  winner's target address
// Purely combinational.
module ifu_redir_arb #(
    parameter int unsigned N_REDIR = 3,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic [N_REDIR-1:0]        valid,
    input  logic [N_REDIR*ADDR_W-1:0] addr,
    output logic [N_REDIR-1:0]        grant,
    output logic                      any_valid,
    output logic [ADDR_W-1:0]         target
);

    // Scan from lowest to highest priority so the lowest valid index wins last.
    always_comb begin
        grant  = '0;
        target = '0;
        for (int k = int'(N_REDIR) - 1; k >= 0; k--) begin
            if (valid[k]) begin
                grant    = '0;
                grant[k] = 1'b1;
                target   = addr[k*ADDR_W +: ADDR_W];
            end
        end
    end

    assign any_valid = |valid;

endmodule

// File: rtl/ifu_pc_gen.sv
// ifu_pc_gen: IFU next-PC generator with prioritised redirects, valid/ready
// fetch handshake, block-aligned sequential advance and a redirect epoch tag.
//   clk, rst        clock, synchronous active-high reset
//   redir_valid_i   per-channel redirect request (channel 0 highest priority)
//   redir_addr_i    packed redirect targets
//   hold_i          stall; suppresses fetch issue
//   fetch_ready_i   memory port accepts the request
//   fetch_valid_o   fetch request valid (combinational)
//   pc_o            fetch address
//   epoch_o         epoch tag of the current request
//   redir_taken_o   one-hot accepted redirect channel (combinational)
//   misalign_o      misaligned-target fault flag
// Optional macro IFU_PC_ALIGN_CHK_EN: a misaligned redirect target is loaded
// raw and parks the generator in FAULT until the next redirect; otherwise the
// low address bits are cleared on load and misalign_o is tied low.
module ifu_pc_gen
    import ifu_pc_gen_pkg::*;
#(
    parameter int unsigned        ADDR_W      = 32,
    parameter logic [ADDR_W-1:0]  RESET_ADDR  = ADDR_W'(DEFAULT_RESET_ADDR),
    parameter int unsigned        FETCH_BYTES = 4,
    parameter int unsigned        N_REDIR     = 3,
    parameter int unsigned        EPOCH_W     = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REDIR-1:0]        redir_valid_i,
    input  logic [N_REDIR*ADDR_W-1:0] redir_addr_i,
    input  logic                      hold_i,
    input  logic                      fetch_ready_i,
    output logic                      fetch_valid_o,
    output logic [ADDR_W-1:0]         pc_o,
    output logic [EPOCH_W-1:0]        epoch_o,
    output logic [N_REDIR-1:0]        redir_taken_o,
    output logic                      misalign_o
);

    localparam logic [ADDR_W-1:0] BLK_MASK   = ~ADDR_W'(blk_off_mask(FETCH_BYTES));
    localparam logic [ADDR_W-1:0] INSTR_MASK = ~ADDR_W'((1 << INSTR_ALIGN_BITS) - 1);
    localparam logic [ADDR_W-1:0] BLK_STEP   = ADDR_W'(FETCH_BYTES);

    pc_state_e           state, state_nxt;
    logic [ADDR_W-1:0]   pc_q, pc_nxt;
    logic [EPOCH_W-1:0]  epoch_q, epoch_nxt;
    logic [N_REDIR-1:0]  grant;
    logic                any_redir;
    logic [ADDR_W-1:0]   redir_tgt;

    ifu_redir_arb #(
        .N_REDIR (N_REDIR),
        .ADDR_W  (ADDR_W)
    ) u_arb (
        .valid     (redir_valid_i),
        .addr      (redir_addr_i),
        .grant     (grant),
        .any_valid (any_redir),
        .target    (redir_tgt)
    );

    assign redir_taken_o = grant;
    assign fetch_valid_o = (state == ST_RUN) & ~hold_i & ~any_redir;
    assign pc_o          = pc_q;
    assign epoch_o       = epoch_q;

`ifdef IFU_PC_ALIGN_CHK_EN
    logic tgt_misaligned;
    assign tgt_misaligned = |(redir_tgt & ~INSTR_MASK);
    assign misalign_o     = (state == ST_FAULT);
`else
    assign misalign_o     = 1'b0;
`endif

    // State, PC and epoch registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_BOOT;
            pc_q    <= RESET_ADDR;
            epoch_q <= '0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            epoch_q <= epoch_nxt;
        end
    end

    // Next state: redirect beats hold, hold beats handshake advance.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        epoch_nxt = epoch_q;
        if (any_redir) begin
            epoch_nxt = epoch_q + EPOCH_W'(1);
`ifdef IFU_PC_ALIGN_CHK_EN
            pc_nxt    = redir_tgt;
            state_nxt = tgt_misaligned ? ST_FAULT : ST_RUN;
`else
            pc_nxt    = redir_tgt & INSTR_MASK;
            state_nxt = ST_RUN;
`endif
        end else begin
            case (state)
                ST_BOOT: state_nxt = ST_RUN;
                ST_RUN: begin
                    // Mid-block targets fetch their partial block once, then realign.
                    if (fetch_valid_o && fetch_ready_i)
                        pc_nxt = (pc_q & BLK_MASK) + BLK_STEP;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_pc_gen.sv
// tb_ifu_pc_gen: self-checking bench for ifu_pc_gen (4-byte instance with a
// behavioural model, plus an 8-byte instance for block-width checks).
module tb_ifu_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  redir_valid;
    logic [95:0] redir_addr;
    logic        hold;
    logic        ready;

    logic        fv, mis, fv8, mis8;
    logic [31:0] pc, pc8;
    logic [2:0]  ep, ep8, taken, taken8;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state (reset address 0, 4-byte blocks, 3-bit epoch).
    logic        c_rst, c_hold, c_ready;
    logic [2:0]  c_valid;
    logic [31:0] c_tgt [3];
    logic [31:0] m_pc;
    int          m_epoch;
    bit          m_boot, m_fault;

    always #5 clk = ~clk;

    ifu_pc_gen dut (
        .clk(clk), .rst(rst), .redir_valid_i(redir_valid), .redir_addr_i(redir_addr),
        .hold_i(hold), .fetch_ready_i(ready), .fetch_valid_o(fv), .pc_o(pc),
        .epoch_o(ep), .redir_taken_o(taken), .misalign_o(mis)
    );

    ifu_pc_gen #(.FETCH_BYTES(8)) dut8 (
        .clk(clk), .rst(rst), .redir_valid_i(redir_valid), .redir_addr_i(redir_addr),
        .hold_i(hold), .fetch_ready_i(ready), .fetch_valid_o(fv8), .pc_o(pc8),
        .epoch_o(ep8), .redir_taken_o(taken8), .misalign_o(mis8)
    );

    function automatic logic m_fv();
        return !m_boot && !m_fault && !c_hold && (c_valid == 3'b000);
    endfunction

    // Lowest set bit of the request vector.
    function automatic logic [2:0] m_taken();
        return c_valid & (~c_valid + 3'd1);
    endfunction

    task automatic apply(input logic r, input logic [2:0] v, input logic [31:0] t0,
                         input logic [31:0] t1, input logic [31:0] t2,
                         input logic h, input logic rd);
        @(negedge clk);
        c_rst = r; c_valid = v; c_hold = h; c_ready = rd;
        c_tgt[0] = t0; c_tgt[1] = t1; c_tgt[2] = t2;
        rst = r; redir_valid = v; redir_addr = {t2, t1, t0}; hold = h; ready = rd;
        #1;
    endtask

    task automatic tick();
        logic [31:0] t;
        bit          adv;
        adv = m_fv() && c_ready;
        @(posedge clk);
        if (c_rst) begin
            m_pc = 32'h0; m_epoch = 0; m_boot = 1; m_fault = 0;
        end else if (c_valid != 3'b000) begin
            t = c_tgt[$clog2(m_taken())];
            m_epoch = (m_epoch + 1) % 8;
            m_boot  = 0;
`ifdef IFU_PC_ALIGN_CHK_EN
            m_pc    = t;
            m_fault = (t % 4) != 0;
`else
            m_pc    = t - (t % 4);
            m_fault = 0;
`endif
        end else if (m_boot) begin
            m_boot = 0;
        end else if (adv) begin
            m_pc = m_pc - (m_pc % 4) + 32'd4;
        end
    endtask

    task automatic test_reset();
        apply(1, 3'b000, 0, 0, 0, 0, 1); tick();
        apply(1, 3'b000, 0, 0, 0, 0, 1);
        n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
        n_tests++; if (ep !== 3'd0) begin n_fail++; $display("FAIL reset_epoch: got %0d expected 0", ep); end
        n_tests++; if (mis !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b expected 0", mis); end
        tick();
        apply(0, 3'b000, 0, 0, 0, 0, 1);
        n_tests++; if (fv !== 1'b0) begin n_fail++; $display("FAIL boot_valid: got %b expected 0", fv); end
        n_tests++; if (taken !== 3'b000) begin n_fail++; $display("FAIL boot_taken: got %b expected 000", taken); end
        tick();
        for (int i = 0; i < 2; i++) begin
            apply(0, 3'b000, 0, 0, 0, 0, 1);
            n_tests++; if (fv !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b expected 1", i, fv); end
            n_tests++; if (pc !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc, 32'(i * 4)); end
            n_tests++; if (ep !== 3'd0) begin n_fail++; $display("FAIL seq_epoch[%0d]: got %0d expected 0", i, ep); end
            tick();
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            apply(0, 3'b000, 0, 0, 0, 0, 0);
            n_tests++; if (pc !== 32'h8) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, pc, 32'h8); end
            n_tests++; if (fv !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, fv); end
            tick();
        end
        apply(0, 3'b000, 0, 0, 0, 0, 1);
        n_tests++; if (pc !== 32'h8) begin n_fail++; $display("FAIL stall_release_pc: got %h expected %h", pc, 32'h8); end
        tick();
        apply(0, 3'b000, 0, 0, 0, 0, 1);
        n_tests++; if (pc !== 32'hC) begin n_fail++; $display("FAIL stall_next_pc: got %h expected %h", pc, 32'hC); end
        tick();
    endtask

    task automatic test_redirect_priority();
        apply(0, 3'b110, 32'h0, 32'h100, 32'h200, 0, 1);
        n_tests++; if (taken !== 3'b010) begin n_fail++; $display("FAIL prio_taken: got %b expected 010", taken); end
        n_tests++; if (fv !== 1'b0) begin n_fail++; $display("FAIL prio_valid: got %b expected 0", fv); end
        tick();
        apply(0, 3'b000, 0, 0, 0, 0, 1);
        n_tests++; if (pc !== 32'h100) begin n_fail++; $display("FAIL prio_pc: got %h expected %h", pc, 32'h100); end
        n_tests++; if (ep !== 3'd1) begin n_fail++; $display("FAIL prio_epoch: got %0d expected 1", ep); end
        tick();
    endtask

    task automatic test_hold_redirect();
        apply(0, 3'b001, 32'h40, 0, 0, 1, 1);
        n_tests++; if (taken !== 3'b001) begin n_fail++; $display("FAIL hold_taken: got %b expected 001", taken); end
        tick();
        for (int i = 0; i < 2; i++) begin
            apply(0, 3'b000, 0, 0, 0, 1, 1);
            n_tests++; if (pc !== 32'h40) begin n_fail++; $display("FAIL hold_pc[%0d]: got %h expected %h", i, pc, 32'h40); end
            n_tests++; if (ep !== 3'd2) begin n_fail++; $display("FAIL hold_epoch[%0d]: got %0d expected 2", i, ep); end
            n_tests++; if (fv !== 1'b0) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b expected 0", i, fv); end
            tick();
        end
        apply(0, 3'b000, 0, 0, 0, 0, 1);
        n_tests++; if (fv !== 1'b1) begin n_fail++; $display("FAIL unhold_valid: got %b expected 1", fv); end
        tick();
    endtask

    task automatic test_fetch8();
        logic [31:0] exp8 [3];
        exp8[0] = 32'h1C; exp8[1] = 32'h20; exp8[2] = 32'h28;
        apply(0, 3'b100, 0, 0, 32'h1C, 0, 1); tick();
        for (int i = 0; i < 3; i++) begin
            apply(0, 3'b000, 0, 0, 0, 0, 1);
            n_tests++; if (pc8 !== exp8[i]) begin n_fail++; $display("FAIL fb8_pc[%0d]: got %h expected %h", i, pc8, exp8[i]); end
            n_tests++; if (fv8 !== 1'b1) begin n_fail++; $display("FAIL fb8_valid[%0d]: got %b expected 1", i, fv8); end
            tick();
        end
        apply(0, 3'b001, 32'hFFFF_FFF8, 0, 0, 0, 1); tick();
        apply(0, 3'b000, 0, 0, 0, 0, 1);
        n_tests++; if (pc8 !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL fb8_top_pc: got %h expected %h", pc8, 32'hFFFF_FFF8); end
        tick();
        apply(0, 3'b000, 0, 0, 0, 0, 1);
        n_tests++; if (pc8 !== 32'h0) begin n_fail++; $display("FAIL fb8_wrap_pc: got %h expected %h", pc8, 32'h0); end
        n_tests++; if (pc !== m_pc) begin n_fail++; $display("FAIL fb4_wrap_pc: got %h expected %h", pc, m_pc); end
        tick();
    endtask

    task automatic test_misalign();
        apply(0, 3'b010, 0, 32'h102, 0, 0, 1); tick();
`ifdef IFU_PC_ALIGN_CHK_EN
        for (int i = 0; i < 2; i++) begin
            apply(0, 3'b000, 0, 0, 0, 0, 1);
            n_tests++; if (pc !== 32'h102) begin n_fail++; $display("FAIL mis_pc[%0d]: got %h expected %h", i, pc, 32'h102); end
            n_tests++; if (mis !== 1'b1) begin n_fail++; $display("FAIL mis_flag[%0d]: got %b expected 1", i, mis); end
            n_tests++; if (fv !== 1'b0) begin n_fail++; $display("FAIL mis_valid[%0d]: got %b expected 0", i, fv); end
            tick();
        end
`else
        apply(0, 3'b000, 0, 0, 0, 0, 1);
        n_tests++; if (pc !== 32'h100) begin n_fail++; $display("FAIL mis_pc: got %h expected %h", pc, 32'h100); end
        n_tests++; if (mis !== 1'b0) begin n_fail++; $display("FAIL mis_flag: got %b expected 0", mis); end
        n_tests++; if (fv !== 1'b1) begin n_fail++; $display("FAIL mis_valid: got %b expected 1", fv); end
        tick();
`endif
        apply(0, 3'b100, 0, 0, 32'h200, 0, 1); tick();
        apply(0, 3'b000, 0, 0, 0, 0, 1);
        n_tests++; if (pc !== 32'h200) begin n_fail++; $display("FAIL mis_exit_pc: got %h expected %h", pc, 32'h200); end
        n_tests++; if (mis !== 1'b0) begin n_fail++; $display("FAIL mis_exit_flag: got %b expected 0", mis); end
        n_tests++; if (fv !== 1'b1) begin n_fail++; $display("FAIL mis_exit_valid: got %b expected 1", fv); end
        tick();
    endtask

    task automatic test_epoch_wrap();
        int e0;
        e0 = m_epoch;
        for (int k = 1; k <= 8; k++) begin
            apply(0, 3'b001, 32'h300 + 32'(k * 4), 0, 0, 0, 1); tick();
            apply(0, 3'b000, 0, 0, 0, 1, 1);
            n_tests++; if (ep !== 3'((e0 + k) % 8)) begin n_fail++; $display("FAIL epoch_wrap[%0d]: got %0d expected %0d", k, ep, (e0 + k) % 8); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        apply(1, 3'b011, 32'h500, 32'h600, 0, 0, 1); tick();
        apply(0, 3'b000, 0, 0, 0, 0, 1);
        n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rmid_pc: got %h expected %h", pc, 32'h0); end
        n_tests++; if (ep !== 3'd0) begin n_fail++; $display("FAIL rmid_epoch: got %0d expected 0", ep); end
        n_tests++; if (fv !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", fv); end
        n_tests++; if (mis !== 1'b0) begin n_fail++; $display("FAIL rmid_misalign: got %b expected 0", mis); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] t [3];
        logic [2:0]  v;
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 3; k++) begin
                t[k] = $urandom;
                if ($urandom_range(0, 1) == 0) t[k] = t[k] & 32'hFFFF_FFFC;
            end
            v = ($urandom_range(0, 9) < 3) ? 3'($urandom_range(1, 7)) : 3'b000;
            apply(($urandom_range(0, 49) == 0), v, t[0], t[1], t[2],
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 7));
            n_tests++; if (fv !== m_fv()) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, fv, m_fv()); end
            n_tests++; if (taken !== m_taken()) begin n_fail++; $display("FAIL rnd_taken[%0d]: got %b expected %b", i, taken, m_taken()); end
            n_tests++; if (pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h expected %h", i, pc, m_pc); end
            n_tests++; if (ep !== 3'(m_epoch)) begin n_fail++; $display("FAIL rnd_epoch[%0d]: got %0d expected %0d", i, ep, m_epoch); end
            n_tests++; if (mis !== m_fault) begin n_fail++; $display("FAIL rnd_misalign[%0d]: got %b expected %b", i, mis, m_fault); end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; redir_valid = '0; redir_addr = '0; hold = 1'b0; ready = 1'b0;
        m_pc = 32'h0; m_epoch = 0; m_boot = 1; m_fault = 0;
        test_reset();
        test_stall();
        test_redirect_priority();
        test_hold_redirect();
        test_fetch8();
        test_misalign();
        test_epoch_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
